// File: rtl/fetch_pkg.sv
// Shared types and sizing helpers for the instruction fetch front end.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    ISSUE = 2'd2,
    DONE  = 2'd3
  } fetch_state_t;

  localparam int PC_W_DEF      = 10;
  localparam int INSTR_W_DEF   = 9;
  localparam int LUT_DEPTH_DEF = 32;

  // Index width for a power-of-two table; a single-entry table still needs one bit.
  function automatic int lut_idx_w(input int depth);
    int w;
    if (depth > 1) begin
      w = $clog2(depth);
    end else begin
      w = 1;
    end
    return w;
  endfunction

  localparam int LUT_IDX_W_DEF = lut_idx_w(LUT_DEPTH_DEF);

endpackage

// File: rtl/branch_lut.sv
// Branch-target register file: synchronous write and clear, asynchronous read.
// A read during a write to the same entry returns the pre-write contents.
module branch_lut
  import fetch_pkg::*;
#(
  parameter int DEPTH = LUT_DEPTH_DEF,
  parameter int W     = PC_W_DEF,
  parameter int IDX_W = lut_idx_w(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_we,
  input  logic [IDX_W-1:0] i_waddr,
  input  logic [W-1:0]     i_wdata,
  input  logic [IDX_W-1:0] i_raddr,
  output logic [W-1:0]     o_rdata
);

  logic [W-1:0] r_mem [DEPTH];

  // Table storage with clear-on-reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: PC sequencing, memory request/response and
// valid/ready hand-off of each instruction to the decoder.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int PC_W      = PC_W_DEF,
  parameter int INSTR_W   = INSTR_W_DEF,
  parameter int LUT_DEPTH = LUT_DEPTH_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [PC_W-1:0]    progEnd,
  output logic [PC_W-1:0]    imemAddr,
  output logic               imemReq,
  input  logic [INSTR_W-1:0] imemData,
  input  logic               imemValid,
  output logic [INSTR_W-1:0] bits,
  output logic               bitsValid,
  input  logic               bitsReady,
  input  logic               branchEnable,
  input  logic [7:0]         LUTIndex,
  input  logic               LUTwrite,
  input  logic [PC_W-1:0]    lutWrData,
  output logic [PC_W-1:0]    pc,
  output logic               done
);

  localparam int IDX_W = lut_idx_w(LUT_DEPTH);

  fetch_state_t       r_state;
  fetch_state_t       w_state_next;
  logic [PC_W-1:0]    r_pc;
  logic [PC_W-1:0]    w_pc_next;
  logic [INSTR_W-1:0] r_bits;
  logic [INSTR_W-1:0] w_bits_next;
  logic               r_bits_valid;
  logic               w_bits_valid_next;
  logic               r_done;
  logic               w_done_next;
  logic               r_imem_req;
  logic               w_imem_req_next;
  logic [IDX_W-1:0]   w_lut_idx;
  logic [PC_W-1:0]    w_lut_target;
  logic               w_handshake;
  logic               w_unused_idx_hi;

  // Upper index bits select nothing; the table wraps modulo its depth.
  assign w_lut_idx       = LUTIndex[IDX_W-1:0];
  assign w_unused_idx_hi = &{1'b0, LUTIndex[7:IDX_W]};
  assign w_handshake     = r_bits_valid & bitsReady;

  branch_lut #(
    .DEPTH (LUT_DEPTH),
    .W     (PC_W),
    .IDX_W (IDX_W)
  ) u_branch_lut (
    .clk     (clk),
    .reset   (reset),
    .i_we    (LUTwrite),
    .i_waddr (w_lut_idx),
    .i_wdata (lutWrData),
    .i_raddr (w_lut_idx),
    .o_rdata (w_lut_target)
  );

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_pc         <= '0;
      r_bits       <= '0;
      r_bits_valid <= 1'b0;
      r_done       <= 1'b0;
      r_imem_req   <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_pc         <= w_pc_next;
      r_bits       <= w_bits_next;
      r_bits_valid <= w_bits_valid_next;
      r_done       <= w_done_next;
      r_imem_req   <= w_imem_req_next;
    end
  end

  // Next-state and next-output decode; imemReq is registered to follow FETCH.
  always_comb begin
    w_state_next      = r_state;
    w_pc_next         = r_pc;
    w_bits_next       = r_bits;
    w_bits_valid_next = r_bits_valid;
    w_done_next       = r_done;
    w_imem_req_next   = r_imem_req;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_next    = FETCH;
          w_pc_next       = '0;
          w_imem_req_next = 1'b1;
        end else begin
          w_state_next    = IDLE;
        end
      end
      FETCH: begin
        if (imemValid) begin
          w_bits_next       = imemData;
          w_bits_valid_next = 1'b1;
          w_imem_req_next   = 1'b0;
          w_state_next      = ISSUE;
        end else begin
          w_state_next      = FETCH;
        end
      end
      ISSUE: begin
        if (w_handshake) begin
          w_bits_valid_next = 1'b0;
          // Taken branch wins over the end-of-program check.
          if (branchEnable) begin
            w_pc_next       = w_lut_target;
            w_imem_req_next = 1'b1;
            w_state_next    = FETCH;
          end else if (r_pc == progEnd) begin
            w_done_next     = 1'b1;
            w_state_next    = DONE;
          end else begin
            w_pc_next       = r_pc + {{(PC_W-1){1'b0}}, 1'b1};
            w_imem_req_next = 1'b1;
            w_state_next    = FETCH;
          end
        end else begin
          w_state_next      = ISSUE;
        end
      end
      DONE: begin
        if (start) begin
          w_done_next     = 1'b0;
          w_pc_next       = '0;
          w_imem_req_next = 1'b1;
          w_state_next    = FETCH;
        end else begin
          w_state_next    = DONE;
        end
      end
      default: begin
        w_state_next      = IDLE;
        w_pc_next         = '0;
        w_bits_next       = '0;
        w_bits_valid_next = 1'b0;
        w_done_next       = 1'b0;
        w_imem_req_next   = 1'b0;
      end
    endcase
  end

  assign imemAddr  = r_pc;
  assign imemReq   = r_imem_req;
  assign bits      = r_bits;
  assign bitsValid = r_bits_valid;
  assign pc        = r_pc;
  assign done      = r_done;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: expected PCs are queued by a small model of
// the sequencing/LUT rules and checked at each decoder handshake.
module tb_fetch_unit;

  localparam int PC_W      = 10;
  localparam int INSTR_W   = 9;
  localparam int LUT_DEPTH = 32;

  logic               clk = 1'b0;
  logic               reset;
  logic               start;
  logic [PC_W-1:0]    progEnd;
  logic [PC_W-1:0]    imemAddr;
  logic               imemReq;
  logic [INSTR_W-1:0] imemData;
  logic               imemValid;
  logic [INSTR_W-1:0] bits;
  logic               bitsValid;
  logic               bitsReady;
  logic               branchEnable;
  logic [7:0]         LUTIndex;
  logic               LUTwrite;
  logic [PC_W-1:0]    lutWrData;
  logic [PC_W-1:0]    pc;
  logic               done;

  int checks   = 0;
  int failures = 0;
  int lat      = 1;

  logic [PC_W-1:0] lut_m [LUT_DEPTH];
  logic [PC_W-1:0] exp_q [$];

  fetch_unit #(.PC_W(PC_W), .INSTR_W(INSTR_W), .LUT_DEPTH(LUT_DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .progEnd      (progEnd),
    .imemAddr     (imemAddr),
    .imemReq      (imemReq),
    .imemData     (imemData),
    .imemValid    (imemValid),
    .bits         (bits),
    .bitsValid    (bitsValid),
    .bitsReady    (bitsReady),
    .branchEnable (branchEnable),
    .LUTIndex     (LUTIndex),
    .LUTwrite     (LUTwrite),
    .lutWrData    (lutWrData),
    .pc           (pc),
    .done         (done)
  );

  always #5 clk = ~clk;

  function automatic logic [INSTR_W-1:0] mem_word(input logic [PC_W-1:0] a);
    logic [INSTR_W-1:0] w;
    w = a[INSTR_W-1:0] + 9'd1;
    return w;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_model();
    for (int i = 0; i < LUT_DEPTH; i++) lut_m[i] = '0;
    exp_q.delete();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    clear_model();
  endtask

  task automatic do_start();
    exp_q.push_back('0);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic lut_write(input logic [7:0] idx, input logic [PC_W-1:0] d);
    LUTIndex  = idx;
    lutWrData = d;
    LUTwrite  = 1'b1;
    tick();
    LUTwrite  = 1'b0;
    lut_m[idx[4:0]] = d;
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (bitsValid === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    check_eq("bits_valid_seen", {31'd0, ok}, 32'd1);
  endtask

  // Hold bitsReady low for n cycles and require the offered instruction to stay put.
  task automatic hold_check(input int n);
    bit ok;
    wait_valid(ok);
    if (ok && exp_q.size() > 0) begin
      for (int i = 0; i < n; i++) begin
        check_eq("hold_bits", {23'd0, bits}, {23'd0, mem_word(exp_q[0])});
        check_eq("hold_valid", {31'd0, bitsValid}, 32'd1);
        check_eq("hold_no_req", {31'd0, imemReq}, 32'd0);
        tick();
      end
    end
  endtask

  // One decoder handshake with optional branch and same-cycle LUT write.
  task automatic consume(input bit br, input logic [7:0] idx, input bit wr, input logic [PC_W-1:0] wd);
    bit ok;
    bit ended;
    logic [PC_W-1:0] e;
    logic [PC_W-1:0] nxt;
    wait_valid(ok);
    if (!ok) return;
    if (exp_q.size() == 0) begin
      check_eq("scoreboard_nonempty", 32'd0, 32'd1);
      return;
    end
    e = exp_q.pop_front();
    check_eq("bits", {23'd0, bits}, {23'd0, mem_word(e)});
    check_eq("pc", {22'd0, pc}, {22'd0, e});
    ended = 1'b0;
    nxt   = '0;
    if (br) begin
      nxt = lut_m[idx[4:0]];
    end else if (e == progEnd) begin
      ended = 1'b1;
    end else begin
      nxt = e + 10'd1;
    end
    if (!ended) exp_q.push_back(nxt);
    bitsReady    = 1'b1;
    branchEnable = br;
    LUTIndex     = idx;
    LUTwrite     = wr;
    lutWrData    = wd;
    tick();
    bitsReady    = 1'b0;
    branchEnable = 1'b0;
    LUTwrite     = 1'b0;
    if (wr) lut_m[idx[4:0]] = wd;
    check_eq("valid_drop", {31'd0, bitsValid}, 32'd0);
    check_eq("done", {31'd0, done}, {31'd0, ended});
    if (!ended) begin
      check_eq("next_req", {31'd0, imemReq}, 32'd1);
      check_eq("next_addr", {22'd0, imemAddr}, {22'd0, nxt});
    end
  endtask

  // Instruction memory: one response per request after `lat` cycles.
  initial begin
    logic [PC_W-1:0] a;
    imemValid = 1'b0;
    imemData  = '0;
    forever begin
      @(posedge clk);
      #1;
      if (imemReq === 1'b1) begin
        a = imemAddr;
        repeat (lat) @(posedge clk);
        #1;
        imemValid = 1'b1;
        imemData  = mem_word(a);
        @(posedge clk);
        #1;
        imemValid = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    reset        = 1'b1;
    start        = 1'b0;
    progEnd      = '0;
    bitsReady    = 1'b0;
    branchEnable = 1'b0;
    LUTIndex     = '0;
    LUTwrite     = 1'b0;
    lutWrData    = '0;
    clear_model();
    do_reset();

    check_eq("rst_pc", {22'd0, pc}, 32'd0);
    check_eq("rst_req", {31'd0, imemReq}, 32'd0);
    check_eq("rst_valid", {31'd0, bitsValid}, 32'd0);
    check_eq("rst_done", {31'd0, done}, 32'd0);
    check_eq("rst_bits", {23'd0, bits}, 32'd0);

    // Straight-line program 0..3 with 1-cycle memory.
    progEnd = 10'd3;
    lat     = 1;
    do_start();
    for (int i = 0; i < 4; i++) consume(1'b0, 8'h00, 1'b0, '0);

    // 3-cycle memory plus backpressure on the second instruction.
    lat = 3;
    do_start();
    consume(1'b0, 8'h00, 1'b0, '0);
    hold_check(5);
    for (int i = 0; i < 3; i++) consume(1'b0, 8'h00, 1'b0, '0);

    // LUT branch, same-cycle write/branch and index wrap.
    lat = 1;
    lut_write(8'h05, 10'd40);
    progEnd = 10'd200;
    do_start();
    consume(1'b0, 8'h00, 1'b0, '0);
    consume(1'b0, 8'h00, 1'b0, '0);
    consume(1'b1, 8'h05, 1'b0, '0);
    lut_write(8'h07, 10'd12);
    consume(1'b1, 8'h07, 1'b1, 10'd99);
    consume(1'b1, 8'h07, 1'b0, '0);
    progEnd = 10'd99;
    consume(1'b1, 8'h45, 1'b0, '0);
    consume(1'b0, 8'h00, 1'b0, '0);
    progEnd = 10'd41;
    consume(1'b0, 8'h00, 1'b0, '0);

    // Reset in FETCH with the response landing the following cycle.
    do_start();
    check_eq("fetch_req", {31'd0, imemReq}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    clear_model();
    tick();
    check_eq("mid_rst_pc", {22'd0, pc}, 32'd0);
    check_eq("mid_rst_req", {31'd0, imemReq}, 32'd0);
    check_eq("mid_rst_valid", {31'd0, bitsValid}, 32'd0);
    check_eq("mid_rst_done", {31'd0, done}, 32'd0);
    check_eq("mid_rst_bits", {23'd0, bits}, 32'd0);
    tick();
    check_eq("stale_resp_ignored", {31'd0, bitsValid}, 32'd0);

    // Restart; the cleared LUT sends a branch through entry 5 back to 0.
    progEnd = 10'd1;
    do_start();
    consume(1'b1, 8'h05, 1'b0, '0);
    consume(1'b0, 8'h00, 1'b0, '0);
    consume(1'b0, 8'h00, 1'b0, '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
